// File: rtl/sub_stream_ctrl.sv
// Sequencer feeding the 8-lane SUB datapath from two operand streams, with credit-gated issue and a FWFT result buffer.
// Optional stall counters are compiled in with `define SUB_CTRL_PERF_EN.
module sub_stream_ctrl #(
  parameter int unsigned MAX_VECTOR_SIZE = 8,
  parameter int unsigned OUT_FIFO_DEPTH  = 8,
  parameter int unsigned LEN_W           = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [LEN_W-1:0]                     length,
  output logic                                 busy,
  output logic                                 done,
  input  logic [8*MAX_VECTOR_SIZE-1:0]         in1_data,
  input  logic                                 in1_valid,
  output logic                                 in1_ready,
  input  logic [8*MAX_VECTOR_SIZE-1:0]         in2_data,
  input  logic                                 in2_valid,
  output logic                                 in2_ready,
  output logic                                 sub_valid_in,
  output logic [8*MAX_VECTOR_SIZE-1:0]         sub_input1,
  output logic [8*MAX_VECTOR_SIZE-1:0]         sub_input2,
  input  logic [8*MAX_VECTOR_SIZE-1:0]         sub_data_o,
  input  logic                                 sub_valid_o,
  output logic [8*MAX_VECTOR_SIZE-1:0]         out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic [$clog2(MAX_VECTOR_SIZE+1)-1:0] out_bytes
`ifdef SUB_CTRL_PERF_EN
  ,
  output logic [31:0]                          perf_stall_in,
  output logic [31:0]                          perf_stall_credit,
  output logic [31:0]                          perf_stall_out
`endif
);

  localparam int unsigned INT8_SIZE = 8;
  localparam int unsigned DATA_W    = INT8_SIZE * MAX_VECTOR_SIZE;
  localparam int unsigned BYTES_W   = $clog2(MAX_VECTOR_SIZE + 1);
  localparam int unsigned CNT_W     = $clog2(OUT_FIFO_DEPTH + 1);
  localparam int unsigned PTR_W     = $clog2(OUT_FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t              state, state_next;
  logic [LEN_W-1:0]    beats, issued, popped, beats_in;
  logic [BYTES_W-1:0]  tail, tail_in;
  logic [CNT_W-1:0]    inflight, fifo_count;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [DATA_W-1:0]   mem [OUT_FIFO_DEPTH];
  logic [DATA_W-1:0]   op1_m, op2_m;
  logic                start_acc, issue, push, pop, credit_ok, last_issue;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = (length == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (issued == beats) state_next = S_DRAIN;
      S_DRAIN: if (popped == beats) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshakes, credit check and tail masking of the outgoing operands
  always_comb begin
    start_acc  = (state == S_IDLE) && start;
    beats_in   = LEN_W'((32'(length) + 32'(MAX_VECTOR_SIZE - 1)) / 32'(MAX_VECTOR_SIZE));
    tail_in    = BYTES_W'(32'(length) % 32'(MAX_VECTOR_SIZE));
    credit_ok  = ((CNT_W+1)'(inflight) + (CNT_W+1)'(fifo_count)) < (CNT_W+1)'(OUT_FIFO_DEPTH);
    issue      = (state == S_ISSUE) && in1_valid && in2_valid && credit_ok && (issued < beats);
    in1_ready  = issue;
    in2_ready  = issue;
    push       = sub_valid_o && (inflight != '0);
    pop        = out_valid && out_ready;
    last_issue = (issued == beats - LEN_W'(1));
    op1_m      = in1_data;
    op2_m      = in2_data;
    for (int unsigned i = 0; i < MAX_VECTOR_SIZE; i++) begin
      if (last_issue && (tail != '0) && (BYTES_W'(i) >= tail)) begin
        op1_m[i*INT8_SIZE +: INT8_SIZE] = '0;
        op2_m[i*INT8_SIZE +: INT8_SIZE] = '0;
      end
    end
  end

  // Job bookkeeping and the registered SUB issue port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      beats        <= '0;
      tail         <= '0;
      issued       <= '0;
      popped       <= '0;
      inflight     <= '0;
      sub_valid_in <= 1'b0;
      sub_input1   <= '0;
      sub_input2   <= '0;
    end else begin
      done         <= (state == S_DONE);
      sub_valid_in <= issue;
      if (start_acc) begin
        busy   <= 1'b1;
        beats  <= beats_in;
        tail   <= tail_in;
        issued <= '0;
        popped <= '0;
      end else begin
        if (state == S_DONE) busy <= 1'b0;
        if (issue && (issued < beats)) issued <= issued + LEN_W'(1);
        if (pop && (popped < beats))   popped <= popped + LEN_W'(1);
      end
      if (issue) begin
        sub_input1 <= op1_m;
        sub_input2 <= op2_m;
      end
      case ({issue, push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Result buffer storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sub_data_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Output beat is gated so an empty buffer presents all-zero sideband
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign out_last  = out_valid && (popped == beats - LEN_W'(1));
  assign out_bytes = !out_valid ? '0 :
                     (out_last && (tail != '0)) ? tail : BYTES_W'(MAX_VECTOR_SIZE);

`ifdef SUB_CTRL_PERF_EN
  // Saturating stall counters, cleared per job
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_in     <= '0;
      perf_stall_credit <= '0;
      perf_stall_out    <= '0;
    end else if (start_acc) begin
      perf_stall_in     <= '0;
      perf_stall_credit <= '0;
      perf_stall_out    <= '0;
    end else begin
      if ((state == S_ISSUE) && !(in1_valid && in2_valid) && (perf_stall_in != '1))
        perf_stall_in <= perf_stall_in + 32'd1;
      if ((state == S_ISSUE) && in1_valid && in2_valid && !credit_ok && (perf_stall_credit != '1))
        perf_stall_credit <= perf_stall_credit + 32'd1;
      if (out_valid && !out_ready && (perf_stall_out != '1))
        perf_stall_out <= perf_stall_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sub_stream_ctrl.sv
// Directed bench for sub_stream_ctrl with a fixed-latency lane-wise subtract model standing in for SUB.
module tb_sub_stream_ctrl;

  localparam int unsigned SUB_LAT = 3;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] length;
  logic        busy, done;
  logic [63:0] in1_data, in2_data;
  logic        in1_valid, in1_ready, in2_valid, in2_ready;
  logic        sub_valid_in, sub_valid_o;
  logic [63:0] sub_input1, sub_input2, sub_data_o;
  logic [63:0] out_data;
  logic        out_valid, out_ready, out_last;
  logic [3:0]  out_bytes;

  logic        pipe_v [SUB_LAT];
  logic [63:0] pipe_d [SUB_LAT];

  int checks = 0, errors = 0;
  int job_beats, job_tail, job_seed;
  int hs_cnt, pop_cnt, sv_cnt, done_cnt, outv_seen, max_occ, cyc;
  int sv_cyc_q[$];

  always #5 clk = ~clk;

  sub_stream_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .length(length), .busy(busy), .done(done),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .in2_data(in2_data), .in2_valid(in2_valid), .in2_ready(in2_ready),
    .sub_valid_in(sub_valid_in), .sub_input1(sub_input1), .sub_input2(sub_input2),
    .sub_data_o(sub_data_o), .sub_valid_o(sub_valid_o),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_bytes(out_bytes)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int s, input int k);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(s*37 + k*11 + i*7 + job_seed);
    return r;
  endfunction

  function automatic logic [63:0] masked(input logic [63:0] d, input int k);
    logic [63:0] r;
    r = d;
    if (k == job_beats - 1 && job_tail != 0)
      for (int i = 0; i < 8; i++) if (i >= job_tail) r[i*8 +: 8] = 8'h00;
    return r;
  endfunction

  function automatic logic [63:0] sub8(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i*8 +: 8] - b[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] exp_out(input int k);
    return sub8(masked(pat(1, k), k), masked(pat(2, k), k));
  endfunction

  function automatic int exp_bytes(input int k);
    return (k == job_beats - 1 && job_tail != 0) ? job_tail : 8;
  endfunction

  // One clock: sample mid-cycle, advance the edge, then drive the next inputs
  task automatic tick();
    logic hs, pp, sv;
    logic [63:0] sd;
    hs = in1_valid && in2_valid && in1_ready && in2_ready;
    pp = out_valid && out_ready;
    sv = sub_valid_in;
    sd = sub8(sub_input1, sub_input2);
    if (out_valid) outv_seen++;
    if (done) done_cnt++;
    if (sv) begin
      check("sub_input1", sub_input1, masked(pat(1, sv_cnt), sv_cnt));
      check("sub_input2", sub_input2, masked(pat(2, sv_cnt), sv_cnt));
      sv_cyc_q.push_back(cyc);
      sv_cnt++;
    end
    if (pp) begin
      check("out_data", out_data, exp_out(pop_cnt));
      check("out_last", 64'(out_last), 64'(pop_cnt == job_beats - 1));
      check("out_bytes", 64'(out_bytes), 64'(exp_bytes(pop_cnt)));
      pop_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = SUB_LAT - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_d[i] = pipe_d[i-1];
    end
    pipe_v[0]   = sv;
    pipe_d[0]   = sd;
    sub_valid_o = pipe_v[SUB_LAT-1];
    sub_data_o  = pipe_d[SUB_LAT-1];
    if (hs) begin
      hs_cnt++;
      in1_data = pat(1, hs_cnt);
      in2_data = pat(2, hs_cnt);
    end
    if (hs_cnt - pop_cnt > max_occ) max_occ = hs_cnt - pop_cnt;
  endtask

  task automatic start_job(input int len, input int seed);
    job_beats = (len + 7) / 8;
    job_tail  = len % 8;
    job_seed  = seed;
    hs_cnt = 0; pop_cnt = 0; sv_cnt = 0; done_cnt = 0; outv_seen = 0; max_occ = 0;
    sv_cyc_q.delete();
    in1_data = pat(1, 0);
    in2_data = pat(2, 0);
    length   = 16'(len);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 64'(done_cnt > 0), 64'(1));
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < int'(SUB_LAT); i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = '0;
    end
    rst = 1'b1; start = 1'b0; length = '0; cyc = 0;
    in1_data = '0; in2_data = '0; in1_valid = 1'b0; in2_valid = 1'b0;
    sub_valid_o = 1'b0; sub_data_o = '0; out_ready = 1'b1;
    job_beats = 0; job_tail = 0; job_seed = 0;
    hs_cnt = 0; pop_cnt = 0; sv_cnt = 0; done_cnt = 0; outv_seen = 0; max_occ = 0;
    repeat (2) tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_in1_ready", 64'(in1_ready), 64'(0));
    check("rst_sub_valid_in", 64'(sub_valid_in), 64'(0));
    check("rst_sub_input1", sub_input1, 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_bytes", 64'(out_bytes), 64'(0));
    check("rst_out_data", out_data, 64'(0));
    rst = 1'b0;
    in1_valid = 1'b1; in2_valid = 1'b1;
    tick();

    // length 16: two full beats back to back
    start_job(16, 3);
    check("len16_busy", 64'(busy), 64'(1));
    run_until_done(100);
    check("len16_issues", 64'(sv_cyc_q.size()), 64'(2));
    if (sv_cyc_q.size() >= 2) check("len16_consec", 64'(sv_cyc_q[1] - sv_cyc_q[0]), 64'(1));
    check("len16_pops", 64'(pop_cnt), 64'(2));
    check("len16_done_once", 64'(done_cnt), 64'(1));
    check("len16_busy_after", 64'(busy), 64'(0));

    // length 13: tail of 5 lanes
    start_job(13, 91);
    run_until_done(100);
    check("len13_pops", 64'(pop_cnt), 64'(2));
    check("len13_tail_in1", 64'(sub_input1[63:40]), 64'(0));
    check("len13_tail_in2", 64'(sub_input2[63:40]), 64'(0));

    // length 0: straight to done
    start_job(0, 5);
    check("len0_done_c1", 64'(done), 64'(0));
    check("len0_busy_c1", 64'(busy), 64'(1));
    tick();
    check("len0_done_c2", 64'(done), 64'(1));
    check("len0_busy_c2", 64'(busy), 64'(0));
    repeat (3) tick();
    check("len0_no_issue", 64'(sv_cnt), 64'(0));
    check("len0_no_out", 64'(outv_seen), 64'(0));
    check("len0_done_once", 64'(done_cnt), 64'(1));

    // length 80 with downstream stalled: credit caps occupancy at the buffer depth
    out_ready = 1'b0;
    start_job(80, 17);
    repeat (50) tick();
    check("stall_ready_low", 64'(in1_ready), 64'(0));
    check("stall_issued", 64'(hs_cnt), 64'(8));
    check("stall_max_occ", 64'(max_occ), 64'(8));
    out_ready = 1'b1;
    run_until_done(300);
    check("len80_pops", 64'(pop_cnt), 64'(10));
    check("len80_issues", 64'(sv_cnt), 64'(10));
    check("len80_max_occ", 64'(max_occ), 64'(8));

    // in2 missing: nothing consumed until both streams are valid
    in2_valid = 1'b0;
    start_job(16, 44);
    repeat (5) tick();
    check("in2low_ready", 64'(in1_ready), 64'(0));
    check("in2low_hs", 64'(hs_cnt), 64'(0));
    in2_valid = 1'b1;
    #1;
    check("in2high_ready", 64'(in1_ready), 64'(1));
    tick();
    check("in2high_hs", 64'(hs_cnt), 64'(1));
    run_until_done(100);
    check("in2_pops", 64'(pop_cnt), 64'(2));

    // Async reset with three beats in flight, then a fresh job
    start_job(80, 60);
    for (int i = 0; i < 20 && hs_cnt < 3; i++) tick();
    check("midrst_hs", 64'(hs_cnt), 64'(3));
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_in1_ready", 64'(in1_ready), 64'(0));
    check("midrst_sub_valid_in", 64'(sub_valid_in), 64'(0));
    check("midrst_sub_input2", sub_input2, 64'(0));
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out_last", 64'(out_last), 64'(0));
    tick();
    rst = 1'b0;
    outv_seen = 0;
    done_cnt  = 0;
    repeat (8) tick();
    check("midrst_late_dropped", 64'(outv_seen), 64'(0));
    check("midrst_no_done", 64'(done_cnt), 64'(0));
    start_job(8, 200);
    run_until_done(100);
    check("post_rst_pops", 64'(pop_cnt), 64'(1));
    check("post_rst_done_once", 64'(done_cnt), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
